// File: rtl/mac_window_sequencer.sv
// mac_window_sequencer
// Sequences one convolution window through an external MAC. The block clears
// the MAC, streams N = KSIZE*KSIZE operand address pairs, and waits for the
// last accumulate. It then quantizes the accumulator to a signed 8-bit value
// and presents that value with a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          window request / cancel
//   act_base, wgt_base    window base addresses (captured on start)
//   shift, relu_en        quantization controls (captured on start)
//   busy                  high outside IDLE
//   rd_en, act_addr,      operand memory read strobe and addresses
//   wgt_addr
//   mac_enable, mac_clear MAC controls
//   mac_acc               signed MAC accumulator
//   out_data, out_valid,  quantized result handshake
//   out_ready
//   done                  one-cycle pulse marking a completed handshake
//
// All outputs are registered. Because of that, done appears in the cycle
// right after the edge where out_valid && out_ready was sampled.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | mac_clear pulse, idx reset
// FETCH  | N read cycles, idx 0..N-1
// DRAIN  | last MAC enable (read latency 1)
// SETTLE | mac_acc final, quantize into out_data
// OUTPUT | hold out_valid/out_data until out_ready
module mac_window_sequencer #(
    parameter int KSIZE  = 3,
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDR_W-1:0]        act_base,
    input  logic [ADDR_W-1:0]        wgt_base,
    input  logic [3:0]               shift,
    input  logic                     relu_en,
    output logic                     busy,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        act_addr,
    output logic [ADDR_W-1:0]        wgt_addr,
    output logic                     mac_enable,
    output logic                     mac_clear,
    input  logic signed [23:0]       mac_acc,
    output logic signed [7:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done
);

    localparam int N     = KSIZE * KSIZE;
    localparam int IDX_W = 9;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] FETCH  = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] SETTLE = 3'd4;
    localparam logic [2:0] OUTPUT = 3'd5;

    logic [2:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [ADDR_W-1:0] act_base_q;
    logic [ADDR_W-1:0] wgt_base_q;
    logic [3:0]        shift_q;
    logic              relu_q;

    logic signed [23:0] q_shift;
    logic signed [23:0] q_relu;
    logic signed [7:0]  q_sat;

    assign idx_nxt = idx + 9'd1;

    always_comb begin
        q_shift = mac_acc >>> shift_q;
        q_relu  = (relu_q && (q_shift < 0)) ? 24'sd0 : q_shift;
        if (q_relu > 24'sd127)
            q_sat = 8'sd127;
        else if (q_relu < -24'sd128)
            q_sat = -8'sd128;
        else
            q_sat = q_relu[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            act_base_q <= '0;
            wgt_base_q <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            busy       <= 1'b0;
            rd_en      <= 1'b0;
            act_addr   <= '0;
            wgt_addr   <= '0;
            mac_enable <= 1'b0;
            mac_clear  <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            mac_clear  <= 1'b0;
            done       <= 1'b0;
            // Read data lands one cycle after the strobe, so the enable trails it.
            mac_enable <= rd_en;
            if (state != IDLE && abort) begin
                // Clearing the MAC on abort leaves it in a known state for the next window.
                state      <= IDLE;
                busy       <= 1'b0;
                rd_en      <= 1'b0;
                mac_enable <= 1'b0;
                mac_clear  <= 1'b1;
                out_valid  <= 1'b0;
                idx        <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            act_base_q <= act_base;
                            wgt_base_q <= wgt_base;
                            shift_q    <= shift;
                            relu_q     <= relu_en;
                            mac_clear  <= 1'b1;
                            busy       <= 1'b1;
                            state      <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        idx      <= '0;
                        rd_en    <= 1'b1;
                        act_addr <= act_base_q;
                        wgt_addr <= wgt_base_q;
                        state    <= FETCH;
                    end
                    FETCH: begin
                        if (idx == LAST) begin
                            rd_en <= 1'b0;
                            state <= DRAIN;
                        end else begin
                            // Address sums wrap naturally at 2^ADDR_W.
                            idx      <= idx_nxt;
                            act_addr <= act_base_q + ADDR_W'(idx_nxt);
                            wgt_addr <= wgt_base_q + ADDR_W'(idx_nxt);
                        end
                    end
                    DRAIN: begin
                        state <= SETTLE;
                    end
                    SETTLE: begin
                        out_data  <= q_sat;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end
                    OUTPUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        rd_en <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_window_sequencer.sv
module tb_mac_window_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort;
    logic [11:0]       act_base, wgt_base;
    logic [3:0]        shift;
    logic              relu_en;
    logic              busy, rd_en, mac_enable, mac_clear, out_valid, out_ready, done;
    logic [11:0]       act_addr, wgt_addr;
    logic signed [23:0] mac_acc;
    logic signed [7:0]  out_data;

    mac_window_sequencer #(.KSIZE(3), .ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .act_base(act_base), .wgt_base(wgt_base), .shift(shift), .relu_en(relu_en),
        .busy(busy), .rd_en(rd_en), .act_addr(act_addr), .wgt_addr(wgt_addr),
        .mac_enable(mac_enable), .mac_clear(mac_clear), .mac_acc(mac_acc),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .done(done)
    );

    always #5 clk = ~clk;

    // Operand memories with one-cycle read latency and a MAC model.
    logic signed [7:0] act_mem [4096];
    logic signed [7:0] wgt_mem [4096];
    logic signed [7:0] act_q, wgt_q;
    always @(posedge clk) if (rd_en) begin
        act_q <= act_mem[act_addr];
        wgt_q <= wgt_mem[wgt_addr];
    end
    always @(posedge clk) begin
        if (mac_clear) mac_acc <= '0;
        else if (mac_enable) mac_acc <= mac_acc + act_q * wgt_q;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;
    int t0 = 0;
    int sb[$];
    int addr_log[$];
    int overlap = 0, done_err = 0, done_cnt = 0;
    logic exp_done = 1'b0, prev_valid = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_done   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (mac_enable && mac_clear) overlap++;
            if (done !== exp_done) done_err++;
            if (done) done_cnt++;
            exp_done = out_valid && out_ready && !abort;
            if (out_valid && !prev_valid) chk("latency", cyc - t0, 12);
            prev_valid = out_valid;
            if (out_valid && out_ready && !abort) begin
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else chk("out_data", int'(out_data), sb.pop_front());
            end
            if (rd_en) addr_log.push_back(int'(act_addr));
        end
    end

    task automatic fill(input int ab, input int wb, input int a, input int w);
        for (int i = 0; i < 9; i++) begin
            act_mem[(ab + i) % 4096] = 8'(a);
            wgt_mem[(wb + i) % 4096] = 8'(w);
        end
    endtask

    task automatic do_start(input int ab, input int wb, input int sh, input logic relu);
        @(posedge clk); #1;
        act_base = 12'(ab); wgt_base = 12'(wb); shift = 4'(sh); relu_en = relu;
        start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!busy && !out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) chk("timeout_idle", 0, 1);
    endtask

    task automatic run_window(input int ab, input int wb, input int a, input int w,
                              input int sh, input logic relu, input int exp);
        fill(ab, wb, a, w);
        sb.push_back(exp);
        do_start(ab, wb, sh, relu);
        wait_idle(60);
    endtask

    task automatic wait_idx4(input int ab);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rd_en && act_addr == 12'(ab + 4)) begin ok = 1'b1; break; end
        end
        if (!ok) chk("timeout_idx4", 0, 1);
    endtask

    int exp_addr[9] = '{4094, 4095, 0, 1, 2, 3, 4, 5, 6};

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        act_base = '0; wgt_base = '0; shift = '0; relu_en = 1'b0;
        for (int i = 0; i < 4096; i++) begin act_mem[i] = '0; wgt_mem[i] = '0; end
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_mac_enable", int'(mac_enable), 0);
        chk("rst_mac_clear", int'(mac_clear), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_act_addr", int'(act_addr), 0);
        chk("rst_wgt_addr", int'(wgt_addr), 0);
        #21 rst_n = 1'b1;

        // Ones, saturation, negative with and without relu.
        run_window(16, 100, 1, 1, 0, 1'b0, 9);
        run_window(200, 300, 127, 127, 4, 1'b0, 127);
        run_window(40, 80, -2, 50, 2, 1'b0, -128);
        run_window(40, 80, -2, 50, 2, 1'b1, 0);

        // Backpressure: hold out_ready low, pulse start while waiting.
        fill(16, 100, 1, 1);
        sb.push_back(9);
        out_ready = 1'b0;
        do_start(16, 100, 0, 1'b0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (out_valid) begin seen = 1'b1; break; end
            end
            if (!seen) chk("timeout_valid", 0, 1);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_data", int'(out_data), 9);
            start = (i == 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        wait_idle(10);
        repeat (20) @(posedge clk);
        #1 chk("bp_start_ignored", int'(busy), 0);

        // Activation address wrap.
        addr_log.delete();
        run_window(4094, 500, 1, 1, 0, 1'b0, 9);
        chk("wrap_len", addr_log.size(), 9);
        for (int i = 0; i < 9 && i < addr_log.size(); i++)
            chk("wrap_addr", addr_log[i], exp_addr[i]);

        // Abort at idx 4.
        fill(16, 100, 1, 1);
        do_start(16, 100, 0, 1'b0);
        wait_idx4(16);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_mac_enable", int'(mac_enable), 0);
        chk("abort_mac_clear", int'(mac_clear), 1);
        chk("abort_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("abort_clear_once", int'(mac_clear), 0);
        repeat (20) @(posedge clk);
        #1 chk("abort_idle", int'(busy), 0);
        run_window(16, 100, 1, 1, 0, 1'b0, 9);

        // Reset at idx 4.
        do_start(16, 100, 0, 1'b0);
        wait_idx4(16);
        rst_n = 1'b0;
        #1;
        chk("rstmid_rd_en", int'(rd_en), 0);
        chk("rstmid_mac_enable", int'(mac_enable), 0);
        chk("rstmid_busy", int'(busy), 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rstmid_no_resume", int'(busy), 0);
        chk("rstmid_no_valid", int'(out_valid), 0);
        run_window(16, 100, 1, 1, 0, 1'b0, 9);

        repeat (3) @(posedge clk);
        #1;
        chk("mac_excl", overlap, 0);
        chk("done_timing", done_err, 0);
        chk("done_count", done_cnt, 8);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_window_sequencer.md
MAC_WINDOW_SEQUENCER -- requirements
Module: mac_window_sequencer

Interface
REQ-001 Parameter KSIZE, 3, kernel edge; window length N = KSIZE*KSIZE (N from 1 to 256).
REQ-002 Parameter ADDR_W, 12, width of the operand memory addresses.
REQ-003 Ports: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to process one window.
- abort  in  1  cancel the current window.
- act_base  in  ADDR_W  activation window base address.
- wgt_base  in  ADDR_W  weight window base address.
- shift  in  4  arithmetic right-shift applied to the result.
- relu_en  in  1  clamp negative results to 0.
- busy  out  1  high in every state except IDLE.
- rd_en  out  1  operand memory read strobe.
- act_addr  out  ADDR_W  activation read address.
- wgt_addr  out  ADDR_W  weight read address.
- mac_enable  out  1  drives the MAC enable.
- mac_clear  out  1  drives the MAC synchronous clear.
- mac_acc  in  24  signed MAC accumulator value.
- out_data  out  8  signed quantized result.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- done  out  1  one-cycle pulse on the output handshake.

Function
REQ-004 States SHALL be IDLE, CLEAR, FETCH, DRAIN, SETTLE and OUTPUT. All outputs SHALL be registered.
REQ-005 IDLE: on start=1, capture act_base, wgt_base, shift and relu_en, then go to CLEAR; start SHALL be ignored in every other state.
REQ-006 CLEAR: mac_clear=1 for exactly one cycle, idx<=0, then go to FETCH.
REQ-007 FETCH: rd_en=1, act_addr=act_base+idx and wgt_addr=wgt_base+idx, each modulo 2^ADDR_W (wrap, no error). Lasts exactly N cycles (idx 0..N-1), then go to DRAIN.
REQ-008 Memory read latency is 1 cycle. mac_enable SHALL equal rd_en delayed by one cycle, so it is high for exactly N cycles; the last of these is the DRAIN cycle.
REQ-009 SETTLE: one cycle in which mac_acc holds the final sum. The block SHALL register the quantized value into out_data, set out_valid, and go to OUTPUT.
REQ-010 Quantization, in order:
- q = mac_acc >>> shift (arithmetic);
- if relu_en and q<0, then q=0;
- saturate q to [-128,127].
REQ-011 OUTPUT: out_valid and out_data SHALL hold stable until out_ready=1. On the cycle out_valid&&out_ready, done=1 for one cycle and the next state is IDLE. A start in that same cycle SHALL be ignored.
REQ-012 Latency: out_valid SHALL first rise N+3 cycles after the start-accept edge (12 cycles for N=9).
REQ-013 mac_enable and mac_clear SHALL never be high in the same cycle. rd_en SHALL be low outside FETCH.
REQ-014 abort=1 in any non-IDLE state: the next state is IDLE. rd_en, mac_enable, out_valid and done SHALL go low the next cycle, and mac_clear SHALL pulse for one cycle. abort has priority over out_ready.
REQ-015 abort in IDLE SHALL have no effect.

Reset
REQ-016 rst_n=0 SHALL immediately force IDLE, with all outputs at 0, idx=0 and the captured registers at 0, independent of clk.
REQ-017 Reset deassertion mid-window SHALL NOT resume the window. The first start after reset SHALL run normally.

Verification
REQ-018 N=9, all operands 1, shift=0, relu_en=0 -> acc=9, out_data=9, out_valid 12 cycles after start, done pulses once.
REQ-019 All operands 127, shift=4 -> acc=145161 (>>>4 = 9072), out_data=127 (saturation).
REQ-020 act=-2, wgt=50: relu_en=0 -> acc=-900, shift=2 -> out_data=-128; relu_en=1 -> out_data=0.
REQ-021 Backpressure: out_ready=0 for 5 cycles -> out_valid and out_data stable and a start pulse ignored; done pulses only on the cycle out_ready rises.
REQ-022 act_base=4094 with ADDR_W=12 -> act_addr sequence 4094, 4095, 0, 1, ..., 6.
REQ-023 abort at FETCH idx=4, and separately rst_n low at idx=4 -> rd_en and mac_enable drop, IDLE reached, no out_valid; abort gives one mac_clear pulse. The following start gives a correct result (REQ-018 values).
